// File: rtl/reg_file_alu.sv
`default_nettype none
// ============================================================================
//  Module      : reg_file_alu
//  Description : Sixteen-entry, 8-bit register file feeding a 2-bit-controlled
//                8-bit ALU. Operand A is R[RA1]. Operand B is R[RA2] or the
//                immediate. The ALU result is written back to R[WA] on the
//                rising clock edge, and R15 is exported as cpu_out.
//                Define REG_FILE_ALU_R0_ZERO_EN to hardwire R0 to zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_file_alu (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] RA1,
    input  logic [3:0] RA2,
    input  logic [3:0] WA,
    input  logic [7:0] immediate,
    input  logic [1:0] ALUControl,
    input  logic       write_enable,
    input  logic       ALUSrc,
    output logic [7:0] ALUResult,
    output logic [7:0] cpu_out,
    output logic       Zero
);

    localparam int          c_NUM_REGS   = 16;
    localparam int          c_OUT_REG    = 15;
    localparam logic [1:0]  c_OP_ADD     = 2'b00;
    localparam logic [1:0]  c_OP_SUB     = 2'b01;
    localparam logic [1:0]  c_OP_AND     = 2'b10;
    localparam logic [1:0]  c_OP_OR      = 2'b11;

`ifdef REG_FILE_ALU_R0_ZERO_EN
    // Registers below this index are never written and stay at their reset value of zero.
    localparam int          c_FIRST_WRITABLE = 1;
`else
    localparam int          c_FIRST_WRITABLE = 0;
`endif

    logic [7:0]             r_regs [c_NUM_REGS];
    logic [c_NUM_REGS-1:0]  w_wr_sel;
    logic [7:0]             w_rd1;
    logic [7:0]             w_rd2;
    logic [7:0]             w_src_b;
    logic [7:0]             w_result;

    // ------------------------------------------------------------------------
    // Storage: one 8-bit register per entry with its own decoded write strobe.
    // Reset clears every entry immediately, discarding any write pending for
    // the next edge.
    // ------------------------------------------------------------------------
    generate
        for (genvar i = 0; i < c_NUM_REGS; i++) begin : g_reg
            if (i < c_FIRST_WRITABLE) begin : g_hardwired
                assign w_wr_sel[i] = 1'b0;
            end else begin : g_writable
                assign w_wr_sel[i] = write_enable && (WA == 4'(i));
            end

            // Write-back of the ALU result into this entry when selected.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_regs[i] <= 8'h00;
                end else if (w_wr_sel[i]) begin
                    r_regs[i] <= w_result;
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Combinational reads. There is no write bypass: a register being written
    // returns its old value until the edge, which makes WA == RA1/RA2 legal.
    // ------------------------------------------------------------------------
    assign w_rd1   = r_regs[RA1];
    assign w_rd2   = r_regs[RA2];
    assign w_src_b = ALUSrc ? immediate : w_rd2;

    // ALU: wrapping add/subtract and bitwise logic on the selected operands.
    always_comb begin
        w_result = 8'h00;
        case (ALUControl)
            c_OP_ADD: w_result = w_rd1 + w_src_b;
            c_OP_SUB: w_result = w_rd1 - w_src_b;
            c_OP_AND: w_result = w_rd1 & w_src_b;
            c_OP_OR:  w_result = w_rd1 | w_src_b;
            default:  w_result = 8'h00;
        endcase
    end

    assign ALUResult = w_result;
    assign Zero      = (w_result == 8'h00);
    assign cpu_out   = r_regs[c_OUT_REG];

endmodule
`default_nettype wire

// File: tb/tb_reg_file_alu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reg_file_alu
//  Description : Self-checking bench for reg_file_alu: directed scenarios
//                followed by randomized operations compared against an
//                array-based reference model, with occasional async resets.
//                Honours REG_FILE_ALU_R0_ZERO_EN in its reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_file_alu;

    logic       clk;
    logic       rst;
    logic [3:0] RA1;
    logic [3:0] RA2;
    logic [3:0] WA;
    logic [7:0] immediate;
    logic [1:0] ALUControl;
    logic       write_enable;
    logic       ALUSrc;
    logic [7:0] ALUResult;
    logic [7:0] cpu_out;
    logic       Zero;

    int errors = 0;
    int checks = 0;
    int model [16];

    reg_file_alu dut (
        .clk          (clk),
        .rst          (rst),
        .RA1          (RA1),
        .RA2          (RA2),
        .WA           (WA),
        .immediate    (immediate),
        .ALUControl   (ALUControl),
        .write_enable (write_enable),
        .ALUSrc       (ALUSrc),
        .ALUResult    (ALUResult),
        .cpu_out      (cpu_out),
        .Zero         (Zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU from plain integer arithmetic.
    function automatic logic [7:0] ref_alu(int a, int b, int op);
        int r;
        case (op)
            0:       r = (a + b) % 256;
            1:       r = (a - b + 256) % 256;
            2:       r = a & b;
            default: r = a | b;
        endcase
        return 8'(r);
    endfunction

    task automatic check8(string tag, logic [7:0] obs, logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check1(string tag, logic obs, logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Hold write_enable for exactly one rising edge.
    task automatic write_edge();
        write_enable = 1'b1;
        @(posedge clk);
        #1;
        write_enable = 1'b0;
    endtask

    initial begin
        int a, b, exp_res;
        logic [7:0] r0_exp;

        rst = 1'b0; RA1 = 4'd0; RA2 = 4'd0; WA = 4'd0; immediate = 8'h00;
        ALUControl = 2'b00; write_enable = 1'b0; ALUSrc = 1'b0;

        // ---- Reset without a clock edge ----
        #1 rst = 1'b1;
        RA1 = 4'd1; ALUSrc = 1'b1; immediate = 8'h00; ALUControl = 2'b00;
        #1;
        check8("reset_alu", ALUResult, 8'h00);
        check1("reset_zero", Zero, 1'b1);
        check8("reset_cpu_out", cpu_out, 8'h00);
        ALUSrc = 1'b0; ALUControl = 2'b11;
        for (int i = 0; i < 16; i++) begin
            RA1 = 4'(i); RA2 = 4'(15 - i);
            #0.2;
            check8("reset_sweep", ALUResult, 8'h00);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) model[i] = 0;

        // ---- Immediate write then register add ----
        RA1 = 4'd0; immediate = 8'd5; ALUSrc = 1'b1; ALUControl = 2'b11; WA = 4'd3;
        #1 check8("imm_or_pre", ALUResult, 8'd5);
        write_edge();
        RA1 = 4'd3; RA2 = 4'd3; ALUSrc = 1'b0; ALUControl = 2'b00;
        #1;
        check8("add_r3_r3", ALUResult, 8'd10);
        check1("add_zero", Zero, 1'b0);

        // ---- Subtract with wrap ----
        ALUSrc = 1'b1; ALUControl = 2'b01; immediate = 8'd5;
        #1;
        check8("sub_eq", ALUResult, 8'h00);
        check1("sub_eq_zero", Zero, 1'b1);
        immediate = 8'd6;
        #1;
        check8("sub_wrap", ALUResult, 8'hFF);
        check1("sub_wrap_zero", Zero, 1'b0);

        // ---- Logic ops ----
        immediate = 8'h0C; ALUControl = 2'b10;
        #1 check8("and_op", ALUResult, 8'h04);
        ALUControl = 2'b11;
        #1 check8("or_op", ALUResult, 8'h0D);

        // ---- cpu_out and write_enable gating ----
        @(negedge clk);
        RA1 = 4'd0; ALUControl = 2'b11; immediate = 8'd15; WA = 4'd15;
        write_edge();
        check8("cpu_out_write", cpu_out, 8'd15);
        immediate = 8'd7;
        @(posedge clk);
        #1 check8("cpu_out_gated", cpu_out, 8'd15);

        // ---- Self-referencing write: old value until the edge ----
        @(negedge clk);
        RA1 = 4'd3; WA = 4'd3; ALUSrc = 1'b1; ALUControl = 2'b00; immediate = 8'd1;
        #1 check8("selfref_before", ALUResult, 8'd6);
        write_edge();
        check8("selfref_after", ALUResult, 8'd7);

        // ---- Async reset mid-cycle loses the pending write ----
        @(negedge clk);
        RA1 = 4'd0; ALUControl = 2'b11; immediate = 8'h5A; WA = 4'd5; write_enable = 1'b1;
        #2 rst = 1'b1;
        #1 check8("async_rst_cpu_out", cpu_out, 8'h00);
        @(posedge clk);
        #1 write_enable = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        RA1 = 4'd5; ALUControl = 2'b00; immediate = 8'h00;
        #1 check8("async_rst_write_lost", ALUResult, 8'h00);
        RA1 = 4'd3;
        #1 check8("async_rst_r3", ALUResult, 8'h00);

        // ---- Write 9 to R0 ----
        @(negedge clk);
        RA1 = 4'd0; ALUControl = 2'b11; immediate = 8'd9; WA = 4'd0;
        write_edge();
        immediate = 8'h00;
`ifdef REG_FILE_ALU_R0_ZERO_EN
        r0_exp = 8'h00;
`else
        r0_exp = 8'd9;
`endif
        #1 check8("r0_after_write", ALUResult, r0_exp);
        for (int i = 0; i < 16; i++) model[i] = 0;
        model[0] = int'(r0_exp);

        // ---- Randomized operations against the array model ----
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            RA1 = 4'($urandom_range(0, 15));
            RA2 = 4'($urandom_range(0, 15));
            WA = 4'($urandom_range(0, 15));
            immediate = 8'($urandom_range(0, 255));
            ALUControl = 2'($urandom_range(0, 3));
            ALUSrc = 1'($urandom_range(0, 1));
            write_enable = 1'($urandom_range(0, 1));
            a = model[RA1];
            b = ALUSrc ? int'(immediate) : model[RA2];
            exp_res = int'(ref_alu(a, b, int'(ALUControl)));
            #1;
            check8("rand_alu", ALUResult, 8'(exp_res));
            check1("rand_zero", Zero, exp_res == 0);
            check8("rand_cpu_out", cpu_out, 8'(model[15]));
            if (n % 60 == 59) begin
                // Reset between edges: registers clear, the pending write is dropped.
                rst = 1'b1;
                for (int i = 0; i < 16; i++) model[i] = 0;
                #1;
                check8("rand_rst_cpu_out", cpu_out, 8'h00);
                check8("rand_rst_alu", ALUResult,
                       ref_alu(0, ALUSrc ? int'(immediate) : 0, int'(ALUControl)));
                @(posedge clk);
                #1 write_enable = 1'b0;
                @(negedge clk);
                rst = 1'b0;
            end else begin
                @(posedge clk);
                if (write_enable) begin
`ifdef REG_FILE_ALU_R0_ZERO_EN
                    if (WA != 4'd0) model[WA] = exp_res;
`else
                    model[WA] = exp_res;
`endif
                end
            end
        end

        // Final sweep of all registers against the model.
        @(negedge clk);
        write_enable = 1'b0; ALUSrc = 1'b1; immediate = 8'h00; ALUControl = 2'b00;
        for (int i = 0; i < 16; i++) begin
            RA1 = 4'(i);
            #0.2;
            check8("final_sweep", ALUResult, 8'(model[i]));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
